// File: rtl/telemetry_rx.sv
// Receive side of the e-bike telemetry UART link (8N1, LSB first, idle high).
// Frames AA 55 + six payload bytes into 12-bit battery, current and torque values.
module telemetry_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] P_SYNC1 = 2'd0;
  localparam logic [1:0] P_SYNC2 = 2'd1;
  localparam logic [1:0] P_PAYLD = 2'd2;

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic start_edge;

  logic [1:0]    bit_st_q, bit_st_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_rdy_q, byte_rdy_d;
  logic          frm_err_q, frm_err_d;

  logic [1:0]  pkt_st_q, pkt_st_d;
  logic [2:0]  idx_q, idx_d;
  logic [11:0] batt_sh_q, batt_sh_d;
  logic [11:0] curr_sh_q, curr_sh_d;
  logic [3:0]  torq_hi_q, torq_hi_d;
  logic [11:0] batt_q, batt_d;
  logic [11:0] curr_q, curr_d;
  logic [11:0] torq_q, torq_d;
  logic        pkt_vld_q, pkt_vld_d;

  // Preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_sync_q;

  always_comb begin
    bit_st_d   = bit_st_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_rdy_d = 1'b0;
    frm_err_d  = 1'b0;
    case (bit_st_q)
      S_IDLE: begin
        if (start_edge) begin
          bit_st_d   = S_START;
          baud_cnt_d = HALF_LD;
        end
      end
      S_START: begin
        if (baud_cnt_q == '0) begin
          if (rx_sync_q) begin
            bit_st_d = S_IDLE;
          end else begin
            bit_st_d   = S_DATA;
            baud_cnt_d = FULL_LD;
            bit_cnt_d  = 4'd0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_cnt_q == '0) begin
          shift_d    = {rx_sync_q, shift_q[7:1]};
          baud_cnt_d = FULL_LD;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) bit_st_d = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_cnt_q == '0) begin
          byte_rdy_d = rx_sync_q;
          frm_err_d  = ~rx_sync_q;
          // A new start edge coinciding with the stop sample must not be lost.
          if (start_edge) begin
            bit_st_d   = S_START;
            baud_cnt_d = HALF_LD;
          end else begin
            bit_st_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end
      end
      default: bit_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_st_q   <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      bit_st_q   <= bit_st_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_rdy_q <= byte_rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Payload is staged in shadow registers so outputs only change on a complete packet.
  always_comb begin
    pkt_st_d  = pkt_st_q;
    idx_d     = idx_q;
    batt_sh_d = batt_sh_q;
    curr_sh_d = curr_sh_q;
    torq_hi_d = torq_hi_q;
    batt_d    = batt_q;
    curr_d    = curr_q;
    torq_d    = torq_q;
    pkt_vld_d = 1'b0;
    if (frm_err_q) begin
      pkt_st_d = P_SYNC1;
      idx_d    = 3'd0;
    end else if (byte_rdy_q) begin
      case (pkt_st_q)
        P_SYNC1: if (shift_q == 8'hAA) pkt_st_d = P_SYNC2;
        P_SYNC2: begin
          if (shift_q == 8'h55) begin
            pkt_st_d = P_PAYLD;
            idx_d    = 3'd0;
          end else if (shift_q != 8'hAA) begin
            pkt_st_d = P_SYNC1;
          end
        end
        P_PAYLD: begin
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd0: batt_sh_d[11:8] = shift_q[3:0];
            3'd1: batt_sh_d[7:0]  = shift_q;
            3'd2: curr_sh_d[11:8] = shift_q[3:0];
            3'd3: curr_sh_d[7:0]  = shift_q;
            3'd4: torq_hi_d       = shift_q[3:0];
            default: begin
              batt_d    = batt_sh_q;
              curr_d    = curr_sh_q;
              torq_d    = {torq_hi_q, shift_q};
              pkt_vld_d = 1'b1;
              pkt_st_d  = P_SYNC1;
              idx_d     = 3'd0;
            end
          endcase
        end
        default: pkt_st_d = P_SYNC1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_st_q  <= P_SYNC1;
      idx_q     <= 3'd0;
      batt_sh_q <= 12'h000;
      curr_sh_q <= 12'h000;
      torq_hi_q <= 4'h0;
      batt_q    <= 12'h000;
      curr_q    <= 12'h000;
      torq_q    <= 12'h000;
      pkt_vld_q <= 1'b0;
    end else begin
      pkt_st_q  <= pkt_st_d;
      idx_q     <= idx_d;
      batt_sh_q <= batt_sh_d;
      curr_sh_q <= curr_sh_d;
      torq_hi_q <= torq_hi_d;
      batt_q    <= batt_d;
      curr_q    <= curr_d;
      torq_q    <= torq_d;
      pkt_vld_q <= pkt_vld_d;
    end
  end

  assign batt_v     = batt_q;
  assign avg_curr   = curr_q;
  assign avg_torque = torq_q;
  assign pkt_vld    = pkt_vld_q;
  assign frm_err    = frm_err_q;

endmodule
